// File: rtl/bc_seq_ctrl_if.sv
// Signal bundle between the basic-computer sequence controller and its datapath.
// The controller takes the master side; the datapath and memory-reference unit take the slave side.
interface bc_seq_ctrl_if;
   logic        start;
   logic [15:0] ir;
   logic        ac_msb;
   logic        ac_lsb;
   logic        ac_zero;
   logic        e_val;
   logic        mr_done;
   logic [3:0]  sc;
   logic        ar_ld_pc;
   logic        ir_ld;
   logic        pc_inc;
   logic        ar_ld_ir;
   logic        ar_ld_mem;
   logic        mr_req;
   logic        ac_clr;
   logic        ac_cmp;
   logic        ac_shr;
   logic        ac_shl;
   logic        ac_inc;
   logic        ff_en;
   logic        e_clr;
   logic        e_indata;
   logic        running;
   logic        halted;

   modport master (
      input  start, ir, ac_msb, ac_lsb, ac_zero, e_val, mr_done,
      output sc, ar_ld_pc, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem, mr_req,
      output ac_clr, ac_cmp, ac_shr, ac_shl, ac_inc,
      output ff_en, e_clr, e_indata, running, halted
   );

   modport slave (
      output start, ir, ac_msb, ac_lsb, ac_zero, e_val, mr_done,
      input  sc, ar_ld_pc, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem, mr_req,
      input  ac_clr, ac_cmp, ac_shr, ac_shl, ac_inc,
      input  ff_en, e_clr, e_indata, running, halted
   );
endinterface

// File: rtl/bc_seq_ctrl.sv
// Basic-computer timing/sequence controller: T0-T2 fetch, T3 register-reference
// execute, hand-off of memory-reference instructions over mr_req/mr_done.
module bc_seq_ctrl #(
   parameter int MR_SC_MAX = 15
) (
   input  logic          clk,
   input  logic          reset,
   bc_seq_ctrl_if.master bus
);

   localparam logic [3:0] SC_MAX   = 4'(MR_SC_MAX);
   localparam logic [3:0] SC_MR_ST = 4'd4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T0   = 3'd1,
      T1   = 3'd2,
      T2   = 3'd3,
      T3   = 3'd4,
      MR   = 3'd5,
      HALT = 3'd6
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] mr_cnt, mr_cnt_nxt;

   logic       ind;
   logic       rr;
   logic       mem;
   logic       skip;

   assign ind  = bus.ir[15];
   assign rr   = (bus.ir[14:12] == 3'd7) && !ind;
   assign mem  = (bus.ir[14:12] != 3'd7);
   // skip tests use the AC/E values as they stand before this instruction
   assign skip = (bus.ir[4] && !bus.ac_msb) ||
                 (bus.ir[3] &&  bus.ac_msb) ||
                 (bus.ir[2] &&  bus.ac_zero) ||
                 (bus.ir[1] && !bus.e_val);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         mr_cnt <= 4'd0;
      end else begin
         state  <= state_nxt;
         mr_cnt <= mr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      mr_cnt_nxt    = mr_cnt;
      bus.sc        = 4'd0;
      bus.ar_ld_pc  = 1'b0;
      bus.ir_ld     = 1'b0;
      bus.pc_inc    = 1'b0;
      bus.ar_ld_ir  = 1'b0;
      bus.ar_ld_mem = 1'b0;
      bus.mr_req    = 1'b0;
      bus.ac_clr    = 1'b0;
      bus.ac_cmp    = 1'b0;
      bus.ac_shr    = 1'b0;
      bus.ac_shl    = 1'b0;
      bus.ac_inc    = 1'b0;
      bus.ff_en     = 1'b0;
      bus.e_clr     = 1'b0;
      bus.e_indata  = 1'b0;
      bus.running   = 1'b0;
      bus.halted    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = T0;
         end
         T0: begin
            bus.running  = 1'b1;
            bus.ar_ld_pc = 1'b1;
            state_nxt    = T1;
         end
         T1: begin
            bus.running = 1'b1;
            bus.sc      = 4'd1;
            bus.ir_ld   = 1'b1;
            bus.pc_inc  = 1'b1;
            state_nxt   = T2;
         end
         T2: begin
            bus.running  = 1'b1;
            bus.sc       = 4'd2;
            bus.ar_ld_ir = 1'b1;
            state_nxt    = T3;
         end
         T3: begin
            bus.running = 1'b1;
            bus.sc      = 4'd3;
            state_nxt   = T0;
            if (rr) begin
               if (bus.ir[11])     bus.ac_clr = 1'b1;
               else if (bus.ir[9]) bus.ac_cmp = 1'b1;
               else if (bus.ir[7]) bus.ac_shr = 1'b1;
               else if (bus.ir[6]) bus.ac_shl = 1'b1;
               else if (bus.ir[5]) bus.ac_inc = 1'b1;
               if (bus.ir[10]) begin
                  bus.ff_en = 1'b1;
                  bus.e_clr = 1'b1;
               end else if (bus.ir[8]) begin
                  bus.ff_en    = 1'b1;
                  bus.e_indata = ~bus.e_val;
               end else if (bus.ir[7]) begin
                  bus.ff_en    = 1'b1;
                  bus.e_indata = bus.ac_lsb;
               end else if (bus.ir[6]) begin
                  bus.ff_en    = 1'b1;
                  bus.e_indata = bus.ac_msb;
               end
               bus.pc_inc = skip;
               if (bus.ir[0]) state_nxt = HALT;
            end else if (mem) begin
               bus.ar_ld_mem = ind;
               mr_cnt_nxt    = SC_MR_ST;
               state_nxt     = MR;
            end
         end
         MR: begin
            bus.running = 1'b1;
            bus.mr_req  = 1'b1;
            bus.sc      = mr_cnt;
            if (mr_cnt != SC_MAX) mr_cnt_nxt = mr_cnt + 4'd1;
            if (bus.mr_done) state_nxt = T0;
         end
         HALT: begin
            bus.halted = 1'b1;
            if (bus.start) state_nxt = T0;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bc_seq_ctrl.sv
// Directed vector bench for bc_seq_ctrl: cycle table plus hand-written
// sequences for MR saturation and asynchronous reset mid-instruction.
module tb_bc_seq_ctrl;

   localparam logic [15:0] ARPC = 16'h8000;
   localparam logic [15:0] IRLD = 16'h4000;
   localparam logic [15:0] PCI  = 16'h2000;
   localparam logic [15:0] ARIR = 16'h1000;
   localparam logic [15:0] ARM  = 16'h0800;
   localparam logic [15:0] MRQ  = 16'h0400;
   localparam logic [15:0] CLR  = 16'h0200;
   localparam logic [15:0] CMP  = 16'h0100;
   localparam logic [15:0] SHR  = 16'h0080;
   localparam logic [15:0] SHL  = 16'h0040;
   localparam logic [15:0] INC  = 16'h0020;
   localparam logic [15:0] FEN  = 16'h0010;
   localparam logic [15:0] ECL  = 16'h0008;
   localparam logic [15:0] EIN  = 16'h0004;
   localparam logic [15:0] RUN  = 16'h0002;
   localparam logic [15:0] HLT  = 16'h0001;

   typedef struct {
      string       nm;
      logic        start;
      logic [15:0] ir;
      logic [3:0]  in4;
      logic        done;
      logic [3:0]  sc;
      logic [15:0] f;
   } vec_t;

   logic   clk;
   logic   rst_n;
   int     checks;
   int     errors;
   vec_t   tbl[$];

   bc_seq_ctrl_if bus ();

   bc_seq_ctrl #(.MR_SC_MAX(15)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] flags();
      return {bus.ar_ld_pc, bus.ir_ld, bus.pc_inc, bus.ar_ld_ir,
              bus.ar_ld_mem, bus.mr_req, bus.ac_clr, bus.ac_cmp,
              bus.ac_shr, bus.ac_shl, bus.ac_inc, bus.ff_en,
              bus.e_clr, bus.e_indata, bus.running, bus.halted};
   endfunction

   task automatic check(string nm, logic [3:0] esc, logic [15:0] ef);
      logic [3:0]  asc;
      logic [15:0] af;
      asc = bus.sc;
      af  = flags();
      checks++;
      if (asc !== esc || af !== ef) begin
         errors++;
         $display("FAIL %s: got sc=%0d flags=%h, want sc=%0d flags=%h",
                  nm, asc, af, esc, ef);
      end
   endtask

   task automatic drive(logic st, logic [15:0] ir, logic [3:0] in4,
                        logic dn);
      bus.start   = st;
      bus.ir      = ir;
      bus.ac_msb  = in4[3];
      bus.ac_lsb  = in4[2];
      bus.ac_zero = in4[1];
      bus.e_val   = in4[0];
      bus.mr_done = dn;
   endtask

   task automatic step(string nm, logic st, logic [15:0] ir,
                       logic [3:0] in4, logic dn,
                       logic [3:0] esc, logic [15:0] ef);
      drive(st, ir, in4, dn);
      @(negedge clk);
      check(nm, esc, ef);
      @(posedge clk);
      #1;
   endtask

   task automatic add(string nm, logic st, logic [15:0] ir,
                      logic [3:0] in4, logic dn,
                      logic [3:0] sc, logic [15:0] f);
      vec_t v;
      v.nm = nm; v.start = st; v.ir = ir; v.in4 = in4;
      v.done = dn; v.sc = sc; v.f = f;
      tbl.push_back(v);
   endtask

   task automatic add_fetch(logic [15:0] ir, logic t1_done);
      add("t0", 1'b0, 16'h0000, 4'b0, 1'b0, 4'd0, ARPC | RUN);
      add("t1", 1'b0, 16'h0000, 4'b0, t1_done, 4'd1, IRLD | PCI | RUN);
      add("t2", 1'b0, ir, 4'b0, 1'b0, 4'd2, ARIR | RUN);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // in4 = {ac_msb, ac_lsb, ac_zero, e_val}
      add("idle", 1'b0, 16'h0000, 4'b0, 1'b0, 4'd0, 16'h0);
      add("idle_start", 1'b1, 16'h0000, 4'b0, 1'b0, 4'd0, 16'h0);
      add_fetch(16'h7100, 1'b1);
      add("cme", 1'b0, 16'h7100, 4'b0001, 1'b0, 4'd3, FEN | RUN);
      add_fetch(16'h7400, 1'b0);
      add("cle", 1'b0, 16'h7400, 4'b0000, 1'b0, 4'd3, FEN | ECL | RUN);
      add_fetch(16'h7080, 1'b0);
      add("cir", 1'b0, 16'h7080, 4'b0100, 1'b0, 4'd3, SHR | FEN | EIN | RUN);
      add_fetch(16'h7040, 1'b0);
      add("cil0", 1'b0, 16'h7040, 4'b0100, 1'b0, 4'd3, SHL | FEN | RUN);
      add_fetch(16'h7040, 1'b0);
      add("cil1", 1'b0, 16'h7040, 4'b1000, 1'b0, 4'd3, SHL | FEN | EIN | RUN);
      add_fetch(16'h7E80, 1'b0);
      add("prio", 1'b0, 16'h7E80, 4'b0101, 1'b0, 4'd3, CLR | FEN | ECL | RUN);
      add_fetch(16'h7120, 1'b0);
      add("inc_cme", 1'b0, 16'h7120, 4'b0000, 1'b0, 4'd3, INC | FEN | EIN | RUN);
      add_fetch(16'h7002, 1'b0);
      add("sze0", 1'b0, 16'h7002, 4'b0000, 1'b0, 4'd3, PCI | RUN);
      add_fetch(16'h7002, 1'b0);
      add("sze1", 1'b0, 16'h7002, 4'b0001, 1'b0, 4'd3, RUN);
      add_fetch(16'h7018, 1'b0);
      add("spa_sna", 1'b0, 16'h7018, 4'b1000, 1'b0, 4'd3, PCI | RUN);
      add_fetch(16'h7004, 1'b0);
      add("sza_nz", 1'b0, 16'h7004, 4'b0000, 1'b0, 4'd3, RUN);
      add_fetch(16'hF001, 1'b0);
      add("io", 1'b0, 16'hF001, 4'b1111, 1'b0, 4'd3, RUN);
      add_fetch(16'h7001, 1'b0);
      add("hlt", 1'b0, 16'h7001, 4'b0000, 1'b0, 4'd3, RUN);
      add("halt", 1'b0, 16'h0000, 4'b0, 1'b0, 4'd0, HLT);
      add("halt_done", 1'b0, 16'h0000, 4'b0, 1'b1, 4'd0, HLT);
      add("halt_start", 1'b1, 16'h0000, 4'b0, 1'b0, 4'd0, HLT);
      add_fetch(16'h9123, 1'b0);
      add("ind_add", 1'b0, 16'h9123, 4'b0, 1'b0, 4'd3, ARM | RUN);
      add("mr4", 1'b0, 16'h9123, 4'b0, 1'b0, 4'd4, MRQ | RUN);
      add("mr5", 1'b0, 16'h9123, 4'b0, 1'b0, 4'd5, MRQ | RUN);
      add("mr6", 1'b0, 16'h9123, 4'b0, 1'b1, 4'd6, MRQ | RUN);
      add_fetch(16'h1123, 1'b0);
      add("dir_and", 1'b0, 16'h1123, 4'b0, 1'b0, 4'd3, RUN);

      rst_n = 1'b0;
      drive(1'b1, 16'h7FFF, 4'b1111, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hold", 4'd0, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].nm, tbl[i].start, tbl[i].ir, tbl[i].in4,
              tbl[i].done, tbl[i].sc, tbl[i].f);

      for (int k = 0; k < 14; k++)
         step("mr_sat", 1'b0, 16'h1123, 4'b0, 1'b0,
              (k < 11) ? 4'(4 + k) : 4'd15, MRQ | RUN);
      step("mr_sat_done", 1'b0, 16'h1123, 4'b0, 1'b1, 4'd15, MRQ | RUN);
      step("mr_t0", 1'b0, 16'h0000, 4'b0, 1'b0, 4'd0, ARPC | RUN);
      step("t1", 1'b0, 16'h0000, 4'b0, 1'b0, 4'd1, IRLD | PCI | RUN);
      step("t2", 1'b0, 16'h9123, 4'b0, 1'b0, 4'd2, ARIR | RUN);
      step("ind2", 1'b0, 16'h9123, 4'b0, 1'b0, 4'd3, ARM | RUN);

      drive(1'b0, 16'h9123, 4'b0, 1'b0);
      @(negedge clk);
      check("mr_pre_rst", 4'd4, MRQ | RUN);
      #2 rst_n = 1'b0;
      #1 check("mr_async_rst", 4'd0, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("idle_a", 1'b0, 16'h9123, 4'b0, 1'b1, 4'd0, 16'h0);
      step("idle_b", 1'b0, 16'h9123, 4'b0, 1'b0, 4'd0, 16'h0);
      step("idle_go", 1'b1, 16'h9123, 4'b0, 1'b0, 4'd0, 16'h0);
      step("t0_res", 1'b0, 16'h0000, 4'b0, 1'b0, 4'd0, ARPC | RUN);
      step("t1", 1'b0, 16'h0000, 4'b0, 1'b0, 4'd1, IRLD | PCI | RUN);
      step("t2", 1'b0, 16'h7100, 4'b0, 1'b0, 4'd2, ARIR | RUN);

      drive(1'b0, 16'h7100, 4'b0001, 1'b0);
      @(negedge clk);
      check("t3_pre_rst", 4'd3, FEN | RUN);
      #2 rst_n = 1'b0;
      #1 check("t3_async_rst", 4'd0, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("idle_c", 1'b0, 16'h7100, 4'b0001, 1'b0, 4'd0, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
